// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded fields into 32-bit words with a one-entry output register.
// Optional macro INSTR_ENCODER_RANGE_CHECK_EN rejects I-type immediates that do not fit in 16 signed bits.
module instr_encoder #(
  parameter int unsigned         ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [31:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [15:0]       count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_SUBI = 6'b000011;
  localparam logic [5:0] OP_ANDI = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b000101;
  localparam logic [5:0] OP_SLTI = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_LB   = 6'b001001;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_SB   = 6'b010001;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_BEQ  = 6'b100011;
  localparam logic [5:0] OP_BNE  = 6'b100111;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111001;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q;
  logic [31:0]         word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         cnt_q;
  logic                err_q;

  logic [31:0]         word_d;
  logic [5:0]          iop;
  logic                ityp;
  logic                legal;
  logic                accept;
  logic                consume;
  logic                load;

  always_comb begin
    word_d = '0;
    iop    = '0;
    ityp   = 1'b0;
    legal  = 1'b1;
    unique case (op_sel)
      4'd0:  word_d = {OP_R, rs, rt, rd, 5'b0, funct};
      4'd1:  begin iop = OP_ADDI; ityp = 1'b1; end
      4'd2:  begin iop = OP_SUBI; ityp = 1'b1; end
      4'd3:  begin iop = OP_ANDI; ityp = 1'b1; end
      4'd4:  begin iop = OP_ORI;  ityp = 1'b1; end
      4'd5:  begin iop = OP_LW;   ityp = 1'b1; end
      4'd6:  begin iop = OP_SW;   ityp = 1'b1; end
      4'd7:  begin iop = OP_LB;   ityp = 1'b1; end
      4'd8:  begin iop = OP_SB;   ityp = 1'b1; end
      4'd9:  begin iop = OP_SLTI; ityp = 1'b1; end
      4'd10: begin iop = OP_BEQ;  ityp = 1'b1; end
      4'd11: begin iop = OP_BNE;  ityp = 1'b1; end
      4'd12: word_d = {OP_J, target};
      4'd13: word_d = {OP_JAL, target};
      4'd14: word_d = {OP_MOVE, rs, 5'b0, rd, 11'b0};
      default: legal = 1'b0;
    endcase
    if (ityp) begin
      word_d = {iop, rs, rt, imm[15:0]};
    end
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // imm must be a sign extension of its low 16 bits
    if (ityp && !((&imm[31:15]) || !(|imm[31:15]))) begin
      legal = 1'b0;
    end
`endif
  end

`ifndef INSTR_ENCODER_RANGE_CHECK_EN
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:16];
`endif

  assign out_valid = (state_q == FULL);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign load      = accept && legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      state_q <= EMPTY;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
    end else begin
      if (consume) begin
        addr_q <= addr_q + ADDR_W'(4);
        if (cnt_q != 16'hFFFF) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      if (accept && !legal) begin
        err_q <= 1'b1;
      end
      if (load) begin
        word_q <= word_d;
      end
      unique case (state_q)
        EMPTY: if (load) state_q <= FULL;
        FULL:  if (consume && !load) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_word = word_q;
  assign out_addr = addr_q;
  assign err      = err_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=4 so address wrap is reachable).
// Directed cases plus a random stream with stalls and flushes.
module tb_instr_encoder;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op_sel;
  logic [4:0]    rs, rt, rd;
  logic [5:0]    funct;
  logic [31:0]   imm;
  logic [25:0]   target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [15:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   sbq[$];
  bit            mv;
  logic [AW-1:0] ma;
  logic [15:0]   mc;
  bit            merr;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic void enc(output bit lg, output logic [31:0] w);
    logic [5:0] opc;
    bit it;
    lg = 1'b1;
    w = '0;
    opc = '0;
    it = 1'b0;
    case (op_sel)
      4'd0:  w = {6'b000000, rs, rt, rd, 5'd0, funct};
      4'd1:  begin opc = 6'b000010; it = 1; end
      4'd2:  begin opc = 6'b000011; it = 1; end
      4'd3:  begin opc = 6'b000100; it = 1; end
      4'd4:  begin opc = 6'b000101; it = 1; end
      4'd5:  begin opc = 6'b001000; it = 1; end
      4'd6:  begin opc = 6'b010000; it = 1; end
      4'd7:  begin opc = 6'b001001; it = 1; end
      4'd8:  begin opc = 6'b010001; it = 1; end
      4'd9:  begin opc = 6'b000111; it = 1; end
      4'd10: begin opc = 6'b100011; it = 1; end
      4'd11: begin opc = 6'b100111; it = 1; end
      4'd12: w = {6'b111000, target};
      4'd13: w = {6'b111001, target};
      4'd14: w = {6'b100000, rs, 5'd0, rd, 11'd0};
      default: lg = 1'b0;
    endcase
    if (it) w = {opc, rs, rt, imm[15:0]};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    if (it && imm[31:15] != 17'h0 && imm[31:15] != 17'h1FFFF)
      lg = 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mv = 0; ma = '0; mc = '0; merr = 0;
    sbq.delete();
  endtask

  // Inputs are already driven; called at posedge+1, returns at next posedge+1.
  task automatic cycle();
    bit acc, cons, lg;
    logic [31:0] w;
    #1;
    check("in_ready", {31'd0, in_ready},
          {31'd0, !flush && (!mv || out_ready)});
    if (flush) begin
      mv = 0; ma = '0; mc = '0;
      sbq.delete();
    end else begin
      acc  = in_valid && (!mv || out_ready);
      cons = mv && out_ready;
      if (cons) begin
        ma = ma + AW'(4);
        if (mc != 16'hFFFF) mc = mc + 1;
        if (sbq.size() > 0) void'(sbq.pop_front());
        mv = 0;
      end
      if (acc) begin
        enc(lg, w);
        if (lg) begin sbq.push_back(w); mv = 1; end
        else merr = 1;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, mv});
    check("count", {16'd0, count}, {16'd0, mc});
    check("err", {31'd0, err}, {31'd0, merr});
    if (mv) begin
      check("out_addr", {28'd0, out_addr}, {28'd0, ma});
      if (sbq.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else check("out_word", out_word, sbq[0]);
    end
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 0;
    op_sel = 0; rs = 0; rt = 0; rd = 0;
    funct = 0; imm = 0; target = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_word", out_word, 32'd0);
    check("rst_addr", {28'd0, out_addr}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] o, input logic [4:0] s,
                     input logic [4:0] t, input logic [31:0] i);
    in_valid = 1; op_sel = o; rs = s; rt = t; imm = i;
  endtask

  logic [AW-1:0] exp_addr [5];

  initial begin
    exp_addr = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0};
    idle();
    rst_n = 1;
    #3;
    do_reset();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // addi, consumed immediately
    req(4'd1, 5'd1, 5'd2, 32'd5);
    out_ready = 1;
    cycle();
    check("addi_word", out_word, 32'h08220005);
    check("addi_addr", {28'd0, out_addr}, 32'd0);
    in_valid = 0;
    cycle();
    check("addi_count", {16'd0, count}, 32'd1);

    // jal held under backpressure
    do_reset();
    in_valid = 1; op_sel = 4'd13; target = 26'h0000010;
    out_ready = 0;
    cycle();
    op_sel = 4'd1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("jal_hold", out_word, 32'hE4000010);
      check("jal_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 0; out_ready = 1;
    cycle();
    check("jal_adv", {28'd0, out_addr}, 32'd4);

    // back-to-back with address wrap
    do_reset();
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      req(4'd2, 5'(k), 5'(k + 1), 32'(k));
      cycle();
      check("b2b_addr", {28'd0, out_addr}, {28'd0, exp_addr[k]});
      check("b2b_rdy", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 0;
    cycle();

    // illegal then rtype
    do_reset();
    req(4'd15, 5'd0, 5'd0, 32'd0);
    cycle();
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_nov", {31'd0, out_valid}, 32'd0);
    req(4'd0, 5'd3, 5'd4, 32'd0);
    rd = 5'd5; funct = 6'h20;
    cycle();
    check("rt_word", out_word, 32'h00642820);
    in_valid = 0;
    cycle();

    // slti with out-of-range immediate
    do_reset();
    req(4'd9, 5'd0, 5'd0, 32'h00008000);
    cycle();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    check("slti_err", {31'd0, err}, 32'd1);
    check("slti_nov", {31'd0, out_valid}, 32'd0);
`else
    check("slti_word", out_word, 32'h1C008000);
    check("slti_err", {31'd0, err}, 32'd0);
`endif
    in_valid = 0;
    cycle();

    // flush over stalled word and pending request
    do_reset();
    req(4'd15, 5'd0, 5'd0, 32'd0);
    cycle();
    req(4'd4, 5'd7, 5'd8, 32'h1234);
    cycle();
    cycle();
    out_ready = 0;
    cycle();
    flush = 1;
    cycle();
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_addr", {28'd0, out_addr}, 32'd0);
    check("fl_count", {16'd0, count}, 32'd0);
    check("fl_err", {31'd0, err}, 32'd1);
    flush = 0; in_valid = 0;
    cycle();

    // reset drops a stalled word
    req(4'd12, 5'd0, 5'd0, 32'd0);
    target = 26'h3ABCDEF;
    out_ready = 0;
    cycle();
    cycle();
    in_valid = 0;
    do_reset();
    req(4'd5, 5'd9, 5'd10, 32'hFFFF_FFF0);
    out_ready = 1;
    cycle();
    check("rst2_addr", {28'd0, out_addr}, 32'd0);
    check("rst2_word", out_word, 32'h212AFFF0);
    in_valid = 0;
    cycle();

    // random stream
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      op_sel    = 4'($urandom_range(0, 15));
      rs        = 5'($urandom);
      rt        = 5'($urandom);
      rd        = 5'($urandom);
      funct     = 6'($urandom);
      target    = 26'($urandom);
      imm       = ($urandom_range(0, 1) != 0) ?
                  32'($signed(16'($urandom))) : 32'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
